secure_packet_rx: RTL and testbench

Base-station receive end of the secure sensor link. Deserialises the 8N1 UART stream produced by the sensor node and frames it into 3-byte packets: SYNC, CIPHER, CHECK. It decrypts the cipher byte, verifies the checksum, and presents the recovered temperature with a one-cycle valid strobe. Framing, checksum and timeout failures are reported as one-cycle error pulses.

---
 rtl/secure_packet_rx.sv | 222 ++++++++++++++++++++++
 tb/tb_secure_packet_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/secure_packet_rx.sv
// Base-station receiver for the secure sensor link: 8N1 UART deserialiser feeding a
// SYNC/CIPHER/CHECK packet framer that decrypts, verifies and publishes the temperature.
module secure_packet_rx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SYNC_BYTE    = 8'h5A,
    parameter logic [7:0]  KEY          = 8'hA5,
    parameter int          TIMEOUT_CLKS = 16 * CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] temp_out,
    output logic       temp_valid,
    output logic       chk_err,
    output logic       frame_err,
    output logic       timeout_err,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);

    localparam logic [1:0] B_IDLE  = 2'd0;
    localparam logic [1:0] B_START = 2'd1;
    localparam logic [1:0] B_DATA  = 2'd2;
    localparam logic [1:0] B_STOP  = 2'd3;

    localparam logic [1:0] P_HUNT       = 2'd0;
    localparam logic [1:0] P_GET_CIPHER = 2'd1;
    localparam logic [1:0] P_GET_CHECK  = 2'd2;

    logic [1:0]       sync_reg;
    logic             rx_s;

    logic [1:0]       bit_state_reg, bit_state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic             armed_reg, armed_next;
    logic             stop_ok, stop_bad;
    logic             byte_stb_reg;
    logic [7:0]       byte_q_reg;
    logic             frame_err_reg;

    logic [1:0]       pkt_state_reg, pkt_state_next;
    logic [7:0]       cipher_reg, cipher_next;
    logic [TO_W-1:0]  idle_reg, idle_next;
    logic [7:0]       temp_reg, temp_next;
    logic             temp_valid_reg, temp_valid_next;
    logic             chk_err_reg, chk_err_next;
    logic             timeout_reg, timeout_next;
    logic [7:0]       plain;
    logic [7:0]       sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], uart_rx};
        end
    end

    assign rx_s = sync_reg[1];

    // armed_reg only learns a high line while idle, so a stop-bit failure with the
    // line still low cannot be mistaken for the next start bit.
    always_comb begin
        bit_state_next = bit_state_reg;
        bit_cnt_next   = bit_cnt_reg;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        armed_next     = armed_reg;
        stop_ok        = 1'b0;
        stop_bad       = 1'b0;
        case (bit_state_reg)
            B_IDLE: begin
                if (armed_reg && !rx_s) begin
                    bit_state_next = B_START;
                    bit_cnt_next   = '0;
                    armed_next     = 1'b0;
                end else begin
                    armed_next = armed_reg | rx_s;
                end
            end
            B_START: begin
                if (bit_cnt_reg == HALF_BIT) begin
                    bit_cnt_next = '0;
                    bit_idx_next = '0;
                    bit_state_next = rx_s ? B_IDLE : B_DATA;
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end
            B_DATA: begin
                if (bit_cnt_reg == LAST_CNT) begin
                    bit_cnt_next = '0;
                    shift_next   = {rx_s, shift_reg[7:1]};
                    if (bit_idx_reg == 3'd7) begin
                        bit_state_next = B_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                if (bit_cnt_reg == LAST_CNT) begin
                    bit_cnt_next   = '0;
                    bit_state_next = B_IDLE;
                    stop_ok        = rx_s;
                    stop_bad       = !rx_s;
                end else begin
                    bit_cnt_next = bit_cnt_reg + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_state_reg <= B_IDLE;
            bit_cnt_reg   <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            armed_reg     <= 1'b0;
            byte_stb_reg  <= 1'b0;
            byte_q_reg    <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            bit_state_reg <= bit_state_next;
            bit_cnt_reg   <= bit_cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            armed_reg     <= armed_next;
            byte_stb_reg  <= stop_ok;
            frame_err_reg <= stop_bad;
            if (stop_ok) begin
                byte_q_reg <= shift_reg;
            end
        end
    end

    assign plain = {cipher_reg[2:0], cipher_reg[7:3]} ^ KEY;
    assign sum   = plain + cipher_reg;

    // The packet FSM reacts to the raw stop failure so busy drops together with frame_err.
    always_comb begin
        pkt_state_next  = pkt_state_reg;
        cipher_next     = cipher_reg;
        idle_next       = idle_reg;
        temp_next       = temp_reg;
        temp_valid_next = 1'b0;
        chk_err_next    = 1'b0;
        timeout_next    = 1'b0;
        case (pkt_state_reg)
            P_GET_CIPHER, P_GET_CHECK: begin
                if (stop_bad) begin
                    pkt_state_next = P_HUNT;
                    idle_next      = '0;
                end else if (byte_stb_reg) begin
                    idle_next = '0;
                    if (pkt_state_reg == P_GET_CIPHER) begin
                        cipher_next    = byte_q_reg;
                        pkt_state_next = P_GET_CHECK;
                    end else begin
                        pkt_state_next = P_HUNT;
                        if (byte_q_reg == sum) begin
                            temp_next       = plain;
                            temp_valid_next = 1'b1;
                        end else begin
                            chk_err_next = 1'b1;
                        end
                    end
                end else if (idle_reg == TO_LAST) begin
                    timeout_next   = 1'b1;
                    pkt_state_next = P_HUNT;
                    idle_next      = '0;
                end else begin
                    idle_next = idle_reg + TO_W'(1);
                end
            end
            default: begin
                idle_next = '0;
                if (byte_stb_reg && byte_q_reg == SYNC_BYTE) begin
                    pkt_state_next = P_GET_CIPHER;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_state_reg  <= P_HUNT;
            cipher_reg     <= '0;
            idle_reg       <= '0;
            temp_reg       <= '0;
            temp_valid_reg <= 1'b0;
            chk_err_reg    <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            pkt_state_reg  <= pkt_state_next;
            cipher_reg     <= cipher_next;
            idle_reg       <= idle_next;
            temp_reg       <= temp_next;
            temp_valid_reg <= temp_valid_next;
            chk_err_reg    <= chk_err_next;
            timeout_reg    <= timeout_next;
        end
    end

    assign temp_out    = temp_reg;
    assign temp_valid  = temp_valid_reg;
    assign chk_err     = chk_err_reg;
    assign frame_err   = frame_err_reg;
    assign timeout_err = timeout_reg;
    assign busy        = (pkt_state_reg != P_HUNT);

endmodule

// File: tb/tb_secure_packet_rx.sv
// Directed bench for secure_packet_rx at 16 clocks per bit: nominal, checksum,
// noise, glitch/framing, timeout and mid-packet reset scenarios.
module tb_secure_packet_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] temp_out;
    logic       temp_valid, chk_err, frame_err, timeout_err, busy;

    int   errors = 0;
    int   checks = 0;
    int   n_valid, n_chk, n_frame, n_to;
    logic [7:0] last_temp;
    logic frame_busy, to_busy;
    time  t_start, t_valid, t_to;

    always #5 clk = ~clk;

    secure_packet_rx #(
        .CLKS_PER_BIT(16),
        .SYNC_BYTE(8'h5A),
        .KEY(8'hA5),
        .TIMEOUT_CLKS(200)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_rx(uart_rx),
        .temp_out(temp_out),
        .temp_valid(temp_valid),
        .chk_err(chk_err),
        .frame_err(frame_err),
        .timeout_err(timeout_err),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Pulse monitor: tallies strobes and checks that at most one fires per cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (temp_valid) begin
                n_valid++;
                last_temp = temp_out;
                t_valid = $time;
            end
            if (chk_err) n_chk++;
            if (frame_err) begin
                n_frame++;
                frame_busy = busy;
            end
            if (timeout_err) begin
                n_to++;
                to_busy = busy;
                t_to = $time;
            end
            if (temp_valid | chk_err | frame_err | timeout_err)
                check("exclusive", 32'(temp_valid) + 32'(chk_err) + 32'(frame_err) + 32'(timeout_err), 1);
        end
    end

    task automatic clear_counts();
        n_valid = 0; n_chk = 0; n_frame = 0; n_to = 0;
        last_temp = 8'h00; frame_busy = 1'b1; to_busy = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            uart_rx = 1'b1;
        end
    endtask

    task automatic check_reset_outputs();
        check("rst temp_out", temp_out, 0);
        check("rst temp_valid", temp_valid, 0);
        check("rst chk_err", chk_err, 0);
        check("rst frame_err", frame_err, 0);
        check("rst timeout_err", timeout_err, 0);
        check("rst busy", busy, 0);
    endtask

    // One 10-bit frame; rst pulses for one cycle at bit-cycle rst_at when in range.
    task automatic send_frame(input logic [7:0] b, input logic stopv, input int rst_at);
        logic [9:0] f;
        f = {stopv, b, 1'b0};
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (i == 0) t_start = $time;
            if (i == rst_at + 1) begin
                check_reset_outputs();
                rst = 1'b0;
            end
            uart_rx = f[i / 16];
            if (i == rst_at) rst = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1, 9999);
    endtask

    initial begin
        clear_counts();
        repeat (4) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        idle(20);

        // Nominal packet
        clear_counts();
        send_byte(8'h5A);
        check("busy after sync", busy, 1);
        send_byte(8'hE5);
        send_byte(8'hFE);
        idle(10);
        check("nom valid count", n_valid, 1);
        check("nom temp", last_temp, 8'h19);
        check("nom temp_out", temp_out, 8'h19);
        check("nom latency", 32'((t_valid - t_start) / 10), 157);
        check("nom errs", n_chk + n_frame + n_to, 0);
        check("nom busy", busy, 0);

        // Bad checksum
        clear_counts();
        send_byte(8'h5A); send_byte(8'hE5); send_byte(8'hFF);
        idle(10);
        check("bad chk count", n_chk, 1);
        check("bad valid count", n_valid, 0);
        check("bad temp_out", temp_out, 8'h19);

        // Noise then packet, then cipher equal to SYNC
        clear_counts();
        send_byte(8'h00); send_byte(8'h33);
        send_byte(8'h5A); send_byte(8'hE5); send_byte(8'hFE);
        idle(10);
        check("noise valid count", n_valid, 1);
        check("noise temp", last_temp, 8'h19);
        check("noise chk", n_chk, 0);
        clear_counts();
        send_byte(8'h5A); send_byte(8'h5A); send_byte(8'h48);
        idle(10);
        check("sync cipher valid", n_valid, 1);
        check("sync cipher temp", temp_out, 8'hEE);

        // Start-bit glitch, then a stop-bit failure inside a packet
        clear_counts();
        repeat (4) begin
            @(negedge clk);
            uart_rx = 1'b0;
        end
        idle(200);
        check("glitch pulses", n_valid + n_chk + n_frame + n_to, 0);
        check("glitch busy", busy, 0);
        send_byte(8'h5A);
        send_frame(8'hE5, 1'b0, 9999);
        idle(20);
        check("frame count", n_frame, 1);
        check("frame busy at pulse", frame_busy, 0);
        check("frame busy after", busy, 0);
        clear_counts();
        send_byte(8'h5A); send_byte(8'hE5); send_byte(8'hFE);
        idle(10);
        check("post-frame valid", n_valid, 1);
        check("post-frame temp", last_temp, 8'h19);

        // Inter-byte timeout
        clear_counts();
        send_byte(8'h5A);
        idle(300);
        check("timeout count", n_to, 1);
        check("timeout latency", 32'((t_to - t_start) / 10), 357);
        check("timeout busy at pulse", to_busy, 0);
        send_byte(8'hE5); send_byte(8'hFE);
        idle(10);
        check("late bytes pulses", n_valid + n_chk, 0);

        // Reset in the middle of the CHECK byte
        send_byte(8'h5A); send_byte(8'hE5);
        send_frame(8'hFE, 1'b1, 80);
        idle(20);
        clear_counts();
        send_byte(8'h5A); send_byte(8'hE5); send_byte(8'hFE);
        idle(10);
        check("post-rst valid", n_valid, 1);
        check("post-rst temp", temp_out, 8'h19);
        check("post-rst errs", n_chk + n_frame + n_to, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
